// File: rtl/serial_tx_pkg.sv
// Shared types and helpers for the serial bit-stream transmitter.
package serial_tx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_t;

    localparam int MAX_WIDTH = 64;

    // Requested lengths beyond the word width send the whole word.
    function automatic int clamp_len(input int len, input int width);
        return (len > width) ? width : len;
    endfunction

endpackage

// File: rtl/serial_bit_tx.sv
// Serial bit-stream transmitter: parallel word in over valid/ready, one bit per
// clock out on x1, MSB-of-window first, zero-gap between back-to-back words.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no word in flight, x1 held low, always ready
// SHIFT | presenting one bit per cycle, ready only during the last bit
module serial_bit_tx
    import serial_tx_pkg::*;
#(
    parameter int WIDTH = MAX_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] in_len,
    output logic             x1,
    output logic             x1_valid,
    output logic             last,
    output logic             busy
);

    tx_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [CNT_W-1:0] len_eff;
    logic [CNT_W-1:0] pad;
    logic             accept;
    logic             load;

    assign len_eff  = CNT_W'(clamp_len(int'(in_len), WIDTH));
    assign pad      = CNT_W'(WIDTH) - len_eff;
    assign in_ready = !reset && ((state == IDLE) || (cnt == CNT_W'(1)));
    assign accept   = in_valid && in_ready;
    assign load     = accept && (len_eff != '0);

    // The window is left-aligned so the serial bit is always the top bit; the
    // zeros shifted in behind it keep x1 low once the word has drained.
    assign x1       = shreg[WIDTH-1];
    assign x1_valid = (state == SHIFT);
    assign busy     = (state == SHIFT);
    assign last     = (state == SHIFT) && (cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            shreg <= shreg_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shreg_n = shreg;
        case (state)
            IDLE: begin
                if (load) begin
                    shreg_n = in_data << pad;
                    cnt_n   = len_eff;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                shreg_n = shreg << 1;
                cnt_n   = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    if (load) begin
                        shreg_n = in_data << pad;
                        cnt_n   = len_eff;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                shreg_n = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_bit_tx.sv
// Bench for serial_bit_tx: a bit-queue model checked every cycle, directed
// literal cases, and a randomized stream reconstruction.
module tb_serial_bit_tx;

    localparam int WIDTH = 64;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [CNT_W-1:0] in_len;
    logic             x1;
    logic             x1_valid;
    logic             last;
    logic             busy;

    serial_bit_tx #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_len   (in_len),
        .x1       (x1),
        .x1_valid (x1_valid),
        .last     (last),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of {bit, last} still to appear on x1; front is the current bit.
    logic [1:0] mq[$];
    bit         chk_en = 0;

    always @(posedge clk) begin
        bit rdy;
        int l;
        rdy = !reset && (mq.size() <= 1);
        if (reset) begin
            mq.delete();
        end else begin
            if (mq.size() != 0) void'(mq.pop_front());
            if (in_valid && rdy) begin
                l = (int'(in_len) > WIDTH) ? WIDTH : int'(in_len);
                for (int k = 0; k < l; k++)
                    mq.push_back({in_data[l-1-k], 1'(k == l - 1)});
            end
        end
    end

    // Capture of what the DUT emitted, for the directed literal checks.
    logic cap_q[$];
    int   cap_lasts = 0;
    int   cyc = 0;
    int   first_v = -1;
    int   last_v = -1;

    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            logic eb, el;
            eb = (mq.size() != 0) ? mq[0][1] : 1'b0;
            el = (mq.size() != 0) ? mq[0][0] : 1'b0;
            chk("in_ready", 64'(in_ready), 64'(!reset && (mq.size() <= 1)));
            chk("x1_valid", 64'(x1_valid), 64'(mq.size() != 0));
            chk("busy",     64'(busy),     64'(mq.size() != 0));
            chk("x1",       64'(x1),       64'(eb));
            chk("last",     64'(last),     64'(el));
            if (x1_valid === 1'b1) begin
                cap_q.push_back(x1);
                if (last === 1'b1) cap_lasts++;
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
            end
        end
    end

    function automatic logic [63:0] cap_val();
        logic [63:0] v = '0;
        foreach (cap_q[i]) v = {v[62:0], cap_q[i]};
        return v;
    endfunction

    task automatic clear_cap();
        cap_q.delete();
        cap_lasts = 0;
        first_v   = -1;
        last_v    = -1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    bit   rec = 0;
    logic exp_stream[$];

    task automatic send(input logic [63:0] d, input int len);
        int   n = 0;
        logic r;
        int   l;
        in_valid = 1'b1;
        in_data  = d;
        in_len   = CNT_W'(len);
        do begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (r !== 1'b1 && n < 300);
        if (r !== 1'b1) chk("send_timeout", 64'd0, 64'd1);
        else if (rec) begin
            l = (len > WIDTH) ? WIDTH : len;
            for (int k = l - 1; k >= 0; k--) exp_stream.push_back(d[k]);
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_len   = '0;
        @(posedge clk);
        #1;
        chk_en = 1;
        wait_cycles(2);
        reset = 1'b0;

        // Reset values and first-cycle readiness.
        @(negedge clk);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_busy",  64'(busy),     64'd0);
        chk("rst_x1",    64'(x1),       64'd0);
        @(posedge clk);
        #1;

        // Basic 8-bit word.
        clear_cap();
        send(64'hB2, 8);
        in_valid = 1'b0;
        wait_cycles(10);
        chk("basic_bits",  cap_val(), 64'hB2);
        chk("basic_len",   64'(cap_q.size()), 64'd8);
        chk("basic_lasts", 64'(cap_lasts), 64'd1);

        // Back-to-back: 101 then 01 with zero gap.
        clear_cap();
        send(64'b101, 3);
        send(64'b01, 2);
        in_valid = 1'b0;
        wait_cycles(6);
        chk("b2b_bits",  cap_val(), 64'b10101);
        chk("b2b_lasts", 64'(cap_lasts), 64'd2);
        chk("b2b_span",  64'(last_v - first_v + 1), 64'd5);

        // Zero length: accepted, nothing emitted.
        clear_cap();
        send(64'hFF, 0);
        in_valid = 1'b0;
        wait_cycles(3);
        chk("len0_bits", 64'(cap_q.size()), 64'd0);
        @(negedge clk);
        chk("len0_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Single bit.
        clear_cap();
        send(64'h1, 1);
        in_valid = 1'b0;
        wait_cycles(3);
        chk("len1_bits",  cap_val(), 64'h1);
        chk("len1_size",  64'(cap_q.size()), 64'd1);
        chk("len1_lasts", 64'(cap_lasts), 64'd1);

        // Over-length clamps to the full word.
        clear_cap();
        send(64'hC3A5_0F1E_8000_0001, 65);
        in_valid = 1'b0;
        wait_cycles(70);
        chk("len65_size", 64'(cap_q.size()), 64'd64);
        chk("len65_bits", cap_val(), 64'hC3A5_0F1E_8000_0001);

        // Reset at bit 3 of a 10-bit word.
        clear_cap();
        send(64'h2D5, 10);
        in_valid = 1'b0;
        wait_cycles(3);
        reset = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
        wait_cycles(2);
        chk("rstmid_size",  64'(cap_q.size()), 64'd4);
        chk("rstmid_bits",  cap_val(), 64'hB);
        chk("rstmid_lasts", 64'(cap_lasts), 64'd0);
        clear_cap();
        send(64'b0110, 4);
        in_valid = 1'b0;
        wait_cycles(6);
        chk("after_rst_bits",  cap_val(), 64'h6);
        chk("after_rst_lasts", 64'(cap_lasts), 64'd1);

        // Held valid with changing data during SHIFT.
        clear_cap();
        send(64'hA5C3, 16);
        for (int i = 0; i < 20; i++) begin
            in_data = {$urandom, $urandom};
            in_len  = CNT_W'(8);
            wait_cycles(1);
        end
        in_valid = 1'b0;
        wait_cycles(12);
        chk("stable_head", 64'(cap_val() >> (cap_q.size() - 16)), 64'hA5C3);

        // Randomized stream.
        clear_cap();
        exp_stream.delete();
        rec = 1;
        for (int w = 0; w < 200; w++) begin
            int sel, len;
            sel = $urandom_range(0, 19);
            if (sel == 0)      len = 0;
            else if (sel == 1) len = $urandom_range(65, 127);
            else               len = $urandom_range(1, 64);
            send({$urandom, $urandom}, len);
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                wait_cycles($urandom_range(1, 3));
            end
        end
        in_valid = 1'b0;
        rec = 0;
        wait_cycles(70);
        begin
            int bad = 0;
            if (cap_q.size() != exp_stream.size()) bad = 1;
            else foreach (cap_q[i]) if (cap_q[i] !== exp_stream[i]) bad++;
            chk("stream_size", 64'(cap_q.size()), 64'(exp_stream.size()));
            chk("stream_bits_bad", 64'(bad), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
